// File: rtl/core_inst_sequencer.sv
// Instruction sequencer for the 3x3 convolution core: weight/activation L0 fill,
// kernel load, execute, OFIFO drain to pmem per kij, then per-pixel accumulation.
module core_inst_sequencer #(
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_ni   = 6,
  parameter int len_onij = 16,
  parameter int len_oni  = 4,
  parameter int len_kij  = 9,
  parameter int len_ki   = 3,
  parameter int w_base   = 1024,
  parameter int gap      = 16,
  parameter int addr_bw  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        sfp_clr,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic        kij_done,
  output logic        busy,
  output logic        done
);

  localparam int CW = 8;
  localparam int AW = addr_bw;
  localparam logic [33:0] RST_INST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_W_GAP, S_A_L0, S_EXEC,
    S_X_GAP, S_DRAIN, S_KDONE, S_ACC, S_DONE
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt, r_rd_cnt, w_rd_cnt, r_wr_cnt, w_wr_cnt;
  logic [CW-1:0]   r_ocol, w_ocol, r_kcol, w_kcol;
  logic [3:0]      r_kij, w_kij, r_o, w_o;
  logic [AW-1:0]   r_pbase, w_pbase, r_obase, w_obase, r_koff, w_koff, r_kbase, w_kbase;
  logic            r_rd_pend, w_rd_pend, r_wr_pend, w_wr_pend, r_armed;

  logic [33:0]     w_inst;
  logic [AW-1:0]   w_acc_addr;
  logic            w_sfp_clr, w_out_valid, w_kij_done, w_busy, w_done;
  logic [3:0]      w_out_idx;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + CW'(1);
    w_kij     = r_kij;
    w_pbase   = r_pbase;
    w_rd_cnt  = r_rd_cnt;
    w_wr_cnt  = r_wr_cnt;
    w_rd_pend = 1'b0;
    w_wr_pend = 1'b0;
    w_o       = r_o;
    w_ocol    = r_ocol;
    w_obase   = r_obase;
    w_kcol    = r_kcol;
    w_koff    = r_koff;
    w_kbase   = r_kbase;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (start && r_armed) begin
          w_state = S_W_L0;
          w_kij   = '0;
          w_pbase = '0;
        end
      end
      S_W_L0:   if (r_cnt == CW'(col))           begin w_state = S_W_LOAD; w_cnt = '0; end
      S_W_LOAD: if (r_cnt == CW'(col - 1))       begin w_state = S_W_GAP;  w_cnt = '0; end
      S_W_GAP:  if (r_cnt == CW'(gap + col - 1)) begin w_state = S_A_L0;   w_cnt = '0; end
      S_A_L0:   if (r_cnt == CW'(len_nij))       begin w_state = S_EXEC;   w_cnt = '0; end
      S_EXEC:   if (r_cnt == CW'(len_nij - 1))   begin w_state = S_X_GAP;  w_cnt = '0; end
      S_X_GAP: begin
        if (r_cnt == CW'(gap - 1)) begin
          w_state  = S_DRAIN;
          w_cnt    = '0;
          w_rd_cnt = '0;
          w_wr_cnt = '0;
        end
      end
      S_DRAIN: begin
        // rd_cnt counts issued reads so a held-high valid never over-issues
        w_cnt     = '0;
        w_rd_pend = ofifo_valid && (r_rd_cnt < CW'(len_nij));
        w_rd_cnt  = r_rd_cnt + CW'(w_rd_pend);
        w_wr_pend = r_rd_pend;
        w_wr_cnt  = r_wr_cnt + CW'(r_wr_pend);
        if (r_wr_pend && (r_wr_cnt == CW'(len_nij - 1))) w_state = S_KDONE;
      end
      S_KDONE: begin
        w_cnt = '0;
        if (r_kij == 4'(len_kij - 1)) begin
          w_state = S_ACC;
          w_o     = '0;
          w_ocol  = '0;
          w_obase = '0;
          w_kcol  = '0;
          w_koff  = '0;
          w_kbase = '0;
        end else begin
          w_state = S_W_L0;
          w_kij   = r_kij + 4'd1;
          w_pbase = r_pbase + AW'(len_nij);
        end
      end
      S_ACC: begin
        // tap counters advance after each read cycle (cnt 1..len_kij)
        if ((r_cnt != '0) && (r_cnt <= CW'(len_kij))) begin
          w_kbase = r_kbase + AW'(len_nij);
          if (r_kcol == CW'(len_ki - 1)) begin
            w_kcol = '0;
            w_koff = r_koff + AW'(len_ni - len_ki + 1);
          end else begin
            w_kcol = r_kcol + CW'(1);
            w_koff = r_koff + AW'(1);
          end
        end
        if (r_cnt == CW'(len_kij + 2)) begin
          w_cnt   = '0;
          w_kcol  = '0;
          w_koff  = '0;
          w_kbase = '0;
          if (r_o == 4'(len_onij - 1)) begin
            w_state = S_DONE;
          end else begin
            w_o = r_o + 4'd1;
            if (r_ocol == CW'(len_oni - 1)) begin
              w_ocol  = '0;
              w_obase = r_obase + AW'(len_ni - len_oni + 1);
            end else begin
              w_ocol  = r_ocol + CW'(1);
              w_obase = r_obase + AW'(1);
            end
          end
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    w_inst      = RST_INST;
    w_sfp_clr   = 1'b0;
    w_out_valid = 1'b0;
    w_out_idx   = '0;
    w_kij_done  = 1'b0;
    w_done      = 1'b0;
    w_busy      = (w_state != S_IDLE);
    w_acc_addr  = w_kbase + w_obase + w_koff;
    case (w_state)
      S_W_L0: begin
        if (w_cnt < CW'(col)) begin
          w_inst[19]   = 1'b0;
          w_inst[17:7] = 11'(AW'(w_base) + AW'(w_cnt));
        end
        if (w_cnt != '0) w_inst[2] = 1'b1;
      end
      S_W_LOAD: begin
        w_inst[3] = 1'b1;
        w_inst[0] = 1'b1;
      end
      S_A_L0: begin
        if (w_cnt < CW'(len_nij)) begin
          w_inst[19]   = 1'b0;
          w_inst[17:7] = 11'(AW'(w_cnt));
        end
        if (w_cnt != '0) w_inst[2] = 1'b1;
      end
      S_EXEC: begin
        w_inst[3] = 1'b1;
        w_inst[1] = 1'b1;
      end
      S_DRAIN: begin
        w_inst[6] = w_rd_pend;
        if (w_wr_pend) begin
          w_inst[32]    = 1'b0;
          w_inst[31]    = 1'b0;
          w_inst[30:20] = 11'(w_pbase + AW'(w_wr_cnt));
        end
      end
      S_KDONE: w_kij_done = 1'b1;
      S_ACC: begin
        if (w_cnt == '0) w_sfp_clr = 1'b1;
        if ((w_cnt != '0) && (w_cnt <= CW'(len_kij))) begin
          w_inst[32]    = 1'b0;
          w_inst[30:20] = 11'(w_acc_addr);
        end
        if ((w_cnt >= CW'(2)) && (w_cnt <= CW'(len_kij + 1))) w_inst[33] = 1'b1;
        if (w_cnt == CW'(len_kij + 2)) begin
          w_out_valid = 1'b1;
          w_out_idx   = w_o;
        end
      end
      S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_kij     <= '0;
      r_pbase   <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
      r_wr_pend <= 1'b0;
      r_o       <= '0;
      r_ocol    <= '0;
      r_obase   <= '0;
      r_kcol    <= '0;
      r_koff    <= '0;
      r_kbase   <= '0;
      r_armed   <= 1'b0;
      inst      <= RST_INST;
      sfp_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      kij_done  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_kij     <= w_kij;
      r_pbase   <= w_pbase;
      r_rd_cnt  <= w_rd_cnt;
      r_wr_cnt  <= w_wr_cnt;
      r_rd_pend <= w_rd_pend;
      r_wr_pend <= w_wr_pend;
      r_o       <= w_o;
      r_ocol    <= w_ocol;
      r_obase   <= w_obase;
      r_kcol    <= w_kcol;
      r_koff    <= w_koff;
      r_kbase   <= w_kbase;
      r_armed   <= 1'b1;
      inst      <= w_inst;
      sfp_clr   <= w_sfp_clr;
      out_valid <= w_out_valid;
      out_idx   <= w_out_idx;
      kij_done  <= w_kij_done;
      busy      <= w_busy;
      done      <= w_done;
    end
  end

endmodule
